button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Front-end for all push-buttons: synchronises, debounces and edge-detects N_BTN raw board inputs.
//  Emits one-cycle press/release pulses, a long-press pulse and optional auto-repeat press pulses.
//  Sits between the board pins and the game-control FSM, which consumes press[] as its btn strobes.
//  Replaces the separate per-button debounce + one-pulse pairs.
// PARAMETERS
//  N_BTN          4     number of independent button channels
//  SYNC_STAGES    2     flip-flop synchroniser depth (>=2)
//  DB_CYCLES      16    consecutive stable cycles required to accept a level change (>=1)
//  HOLD_CYCLES    64    cycles of accepted-high level before long_press / first repeat (>DB_CYCLES)
//  REPEAT_CYCLES  16    period between auto-repeat press pulses (>=2)
//  CNT_W          16    internal counter width; every cycle parameter must be < 2**CNT_W
// PORTS
//  clk         in   1      system clock, all logic on posedge
//  rst         in   1      synchronous, active-high reset
//  btn_raw     in   N_BTN  asynchronous raw button levels, 1 = pressed
//  repeat_en   in   N_BTN  per-channel auto-repeat enable, sampled every cycle
//  level       out  N_BTN  debounced button level
//  press       out  N_BTN  1-cycle pulse on accepted press and on each auto-repeat
//  release     out  N_BTN  1-cycle pulse on accepted release
//  long_press  out  N_BTN  1-cycle pulse once per hold, when HOLD_CYCLES is reached
// BEHAVIOUR
//  Reset: synchroniser flops, counters and all outputs go to 0; FSM goes to REL; effective on the clock edge rst is sampled.
//  Synchroniser: SYNC_STAGES-deep shift register per channel; sync = last stage.
//  Debounce counter db_cnt:
//   - cleared to 0 in every cycle where sync == level
//   - incremented in every cycle where sync != level
//   - on the cycle it would reach DB_CYCLES: level toggles and db_cnt clears
//  Latency: raw change to level change is SYNC_STAGES + DB_CYCLES edges (18 at defaults).
//  Glitch rule: a pulse shorter than DB_CYCLES cycles after sync never changes level.
//  press / release are registered together with level: a pulse is high in the first cycle of new level only.
//  Per-channel FSM, with hold counter hcnt:
//   REL:  level=0. On level 0->1: go PRS, hcnt=1, press=1.
//   PRS:  hcnt++ each cycle, saturating at HOLD_CYCLES.
//         When hcnt reaches HOLD_CYCLES: long_press=1. If repeat_en: press=1, go RPT, hcnt=1.
//         Otherwise stay PRS, saturated, with no further pulses.
//   RPT:  hcnt++. When hcnt reaches REPEAT_CYCLES: press=1, hcnt=1.
//         If repeat_en=0, go PRS, saturated: no further repeats, no second long_press.
//   Any state, level 1->0: go REL, hcnt=0, release=1. Release has priority over a coincident repeat press.
//  Long-press timing: long_press and the first repeat press occur HOLD_CYCLES cycles after the initial press pulse.
//   Later repeat presses follow every REPEAT_CYCLES cycles.
//  repeat_en rising while already saturated in PRS: no effect until the next hold.
//  Channels are fully independent; simultaneous events on different channels all pulse in the same cycle.
//  Reset mid-hold: outputs drop to 0. A button still held re-debounces from level=0 and produces a fresh press after 18 cycles at defaults.
// STRUCTURE
//  Shared header btn_pkg.vh holds:
//   - FSM state encodings REL=2'd0, PRS=2'd1, RPT=2'd2
//   - default cycle constants, with the simulation variant DB_CYCLES=4, HOLD_CYCLES=16
//  Sub-module btn_channel covers one button: synchroniser, debounce, FSM and pulse registers.
//  button_conditioner is a generate loop of N_BTN btn_channel instances; it has no cross-channel logic.
// TESTING
//  All cases use defaults, with cycle 0 = first edge sampling the new raw value.
//  1 Clean press, hold 40, release: level high at cycles 18..58. press at 18, release at 58. No long_press.
//  2 Bounce: raw toggles every 3 cycles for 30 cycles, then settles at 0: level stays 0, no pulses at all.
//  3 Hold 200 cycles, repeat_en=1: press at 18, 82, 98, 114 ... (period 16). long_press only at 82. release at 218.
//  4 Same hold, repeat_en=0: press at 18 only, long_press at 82. Dropping repeat_en mid-RPT stops repeats next period.
//  5 rst for 1 cycle at cycle 50 while held: all outputs 0 at 51. press again at 69, long_press at 133.
//  6 btn0 and btn3 pressed in the same cycle, btn3 released at cycle 30: identical press timing on both. Only btn3 releases, at 48.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
`default_nettype none
// button_conditioner_pkg: shared FSM encoding and cycle constants (rev 1.0)
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    REL = 2'd0,
    PRS = 2'd1,
    RPT = 2'd2
  } btn_state_e;

  localparam int N_BTN_DEF         = 4;
  localparam int SYNC_STAGES_DEF   = 2;
  localparam int DB_CYCLES_DEF     = 16;
  localparam int HOLD_CYCLES_DEF   = 64;
  localparam int REPEAT_CYCLES_DEF = 16;
  localparam int CNT_W_DEF         = 16;

  // Shortened timing for quick simulation runs
  localparam int DB_CYCLES_SIM     = 4;
  localparam int HOLD_CYCLES_SIM   = 16;

endpackage
`default_nettype wire

// File: rtl/button_conditioner_if.sv
`default_nettype none
// button_conditioner_if: raw button inputs and conditioned event outputs (rev 1.0)
interface button_conditioner_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] repeat_en;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] released;
  logic [N_BTN-1:0] long_press;

  modport master (output btn_raw, repeat_en, input level, press, released, long_press);
  modport slave  (input btn_raw, repeat_en, output level, press, released, long_press);
endinterface
`default_nettype wire

// File: rtl/button_conditioner_btn_channel.sv
`default_nettype none
// btn_channel: one button - synchroniser, debounce, hold/repeat FSM, pulse registers (rev 1.0)
module btn_channel
  import button_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int DB_CYCLES     = DB_CYCLES_DEF,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  input  logic repeat_en_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES);
  // One past HOLD marks a hold that has already been reported
  localparam logic [CNT_W-1:0] HOLD_DONE = CNT_W'(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] REP_MAX   = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0]       hcnt_q, hcnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   long_q, long_d;
  btn_state_e             state_q, state_d;
  logic                   sync_w, rise_w, fall_w;

  assign sync_w = sync_q[SYNC_STAGES-1];

  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (sync_w != level_q) begin
      if (db_cnt_q == DB_LAST) level_d = ~level_q;
      else                     db_cnt_d = db_cnt_q + ONE;
    end
  end

  assign rise_w = level_d & ~level_q;
  assign fall_w = ~level_d & level_q;

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    if (fall_w) begin
      state_d   = REL;
      hcnt_d    = '0;
      release_d = 1'b1;
    end else begin
      case (state_q)
        REL: begin
          if (rise_w) begin
            state_d = PRS;
            hcnt_d  = ONE;
            press_d = 1'b1;
          end
        end
        PRS: begin
          if (hcnt_q < HOLD_MAX) begin
            hcnt_d = hcnt_q + ONE;
          end else if (hcnt_q == HOLD_MAX) begin
            long_d = 1'b1;
            if (repeat_en_i) begin
              press_d = 1'b1;
              state_d = RPT;
              hcnt_d  = ONE;
            end else begin
              hcnt_d = HOLD_DONE;
            end
          end
        end
        RPT: begin
          if (!repeat_en_i) begin
            state_d = PRS;
            hcnt_d  = HOLD_DONE;
          end else if (hcnt_q == REP_MAX) begin
            press_d = 1'b1;
            hcnt_d  = ONE;
          end else begin
            hcnt_d = hcnt_q + ONE;
          end
        end
        default: begin
          state_d = REL;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      db_cnt_q  <= '0;
      hcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      state_q   <= REL;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_raw_i};
      db_cnt_q  <= db_cnt_d;
      hcnt_q    <= hcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      state_q   <= state_d;
    end
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_press_o = long_q;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// button_conditioner: N_BTN independent button conditioning channels (rev 1.0)
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BTN         = N_BTN_DEF,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int DB_CYCLES     = DB_CYCLES_DEF,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  btn_if
);

  logic [N_BTN-1:0] level_w, press_w, release_w, long_w;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DB_CYCLES    (DB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W        (CNT_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .btn_raw_i   (btn_if.btn_raw[g]),
      .repeat_en_i (btn_if.repeat_en[g]),
      .level_o     (level_w[g]),
      .press_o     (press_w[g]),
      .release_o   (release_w[g]),
      .long_press_o(long_w[g])
    );
  end

  assign btn_if.level      = level_w;
  assign btn_if.press      = press_w;
  assign btn_if.released   = release_w;
  assign btn_if.long_press = long_w;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// tb_button_conditioner: directed stimulus with an event scoreboard
module tb_button_conditioner;

  localparam int K_UP   = 0;
  localparam int K_DN   = 1;
  localparam int K_PRS  = 2;
  localparam int K_REL  = 3;
  localparam int K_LONG = 4;

  typedef struct {
    int stamp;
    int ch;
    int kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ecnt = 0;
  int   checks = 0;
  int   failures = 0;
  int   base = 0;
  bit   mon_en = 1'b0;
  logic [3:0] prev_level = '0;
  ev_t  sb[$];

  button_conditioner_if #(.N_BTN(4)) bus ();

  button_conditioner dut (
    .clk   (clk),
    .rst   (rst),
    .btn_if(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic expect_ev(input int n, input int ch, input int kind);
    ev_t e;
    e.stamp = base + n;
    e.ch    = ch;
    e.kind  = kind;
    sb.push_back(e);
  endtask

  task automatic observe(input int stamp, input int ch, input int kind);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL event: unexpected stamp=%0d ch=%0d kind=%0d, required none", stamp - base, ch, kind);
    end else begin
      e = sb.pop_front();
      if (e.stamp != stamp || e.ch != ch || e.kind != kind) begin
        failures++;
        $display("FAIL event: got rel_cyc=%0d ch=%0d kind=%0d, required rel_cyc=%0d ch=%0d kind=%0d",
                 stamp - base, ch, kind, e.stamp - base, e.ch, e.kind);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < 4; c++) begin
        if (bus.level[c] && !prev_level[c]) observe(ecnt, c, K_UP);
        if (!bus.level[c] && prev_level[c]) observe(ecnt, c, K_DN);
        if (bus.press[c])      observe(ecnt, c, K_PRS);
        if (bus.released[c])   observe(ecnt, c, K_REL);
        if (bus.long_press[c]) observe(ecnt, c, K_LONG);
      end
      prev_level = bus.level;
    end
  end

  task automatic start_case();
    @(negedge clk);
    base = ecnt;
  endtask

  initial begin
    bus.btn_raw   = '0;
    bus.repeat_en = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.level, bus.press, bus.released, bus.long_press} != 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0000",
               {bus.level, bus.press, bus.released, bus.long_press});
    end
    prev_level = bus.level;
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);

    // Clean press, hold 40, release
    start_case();
    expect_ev(18, 0, K_UP); expect_ev(18, 0, K_PRS);
    expect_ev(58, 0, K_DN); expect_ev(58, 0, K_REL);
    bus.btn_raw[0] = 1'b1;
    repeat (40) @(negedge clk);
    bus.btn_raw[0] = 1'b0;
    repeat (40) @(negedge clk);

    // Bounce: toggles every 3 cycles, never accepted
    start_case();
    for (int i = 0; i < 10; i++) begin
      bus.btn_raw[1] = (i % 2 == 0);
      repeat (3) @(negedge clk);
    end
    bus.btn_raw[1] = 1'b0;
    repeat (40) @(negedge clk);

    // Long hold with auto-repeat
    start_case();
    expect_ev(18, 1, K_UP); expect_ev(18, 1, K_PRS);
    expect_ev(82, 1, K_PRS); expect_ev(82, 1, K_LONG);
    for (int n = 98; n <= 210; n += 16) expect_ev(n, 1, K_PRS);
    expect_ev(218, 1, K_DN); expect_ev(218, 1, K_REL);
    bus.btn_raw[1] = 1'b1;
    bus.repeat_en[1] = 1'b1;
    repeat (200) @(negedge clk);
    bus.btn_raw[1] = 1'b0;
    repeat (40) @(negedge clk);
    bus.repeat_en[1] = 1'b0;

    // Long hold without repeat
    start_case();
    expect_ev(18, 2, K_UP); expect_ev(18, 2, K_PRS);
    expect_ev(82, 2, K_LONG);
    expect_ev(218, 2, K_DN); expect_ev(218, 2, K_REL);
    bus.btn_raw[2] = 1'b1;
    repeat (200) @(negedge clk);
    bus.btn_raw[2] = 1'b0;
    repeat (40) @(negedge clk);

    // Repeat enable dropped mid-repeat
    start_case();
    expect_ev(18, 2, K_UP); expect_ev(18, 2, K_PRS);
    expect_ev(82, 2, K_PRS); expect_ev(82, 2, K_LONG);
    expect_ev(98, 2, K_PRS);
    expect_ev(218, 2, K_DN); expect_ev(218, 2, K_REL);
    bus.btn_raw[2] = 1'b1;
    bus.repeat_en[2] = 1'b1;
    repeat (100) @(negedge clk);
    bus.repeat_en[2] = 1'b0;
    repeat (100) @(negedge clk);
    bus.btn_raw[2] = 1'b0;
    repeat (40) @(negedge clk);

    // Reset mid-hold, button kept pressed
    start_case();
    expect_ev(18, 0, K_UP); expect_ev(18, 0, K_PRS);
    expect_ev(51, 0, K_DN);
    expect_ev(69, 0, K_UP); expect_ev(69, 0, K_PRS);
    expect_ev(133, 0, K_LONG);
    expect_ev(168, 0, K_DN); expect_ev(168, 0, K_REL);
    bus.btn_raw[0] = 1'b1;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (99) @(negedge clk);
    bus.btn_raw[0] = 1'b0;
    repeat (40) @(negedge clk);

    // Two channels pressed together, only one released early
    start_case();
    expect_ev(18, 0, K_UP); expect_ev(18, 0, K_PRS);
    expect_ev(18, 3, K_UP); expect_ev(18, 3, K_PRS);
    expect_ev(48, 3, K_DN); expect_ev(48, 3, K_REL);
    expect_ev(82, 0, K_LONG);
    expect_ev(118, 0, K_DN); expect_ev(118, 0, K_REL);
    bus.btn_raw[0] = 1'b1;
    bus.btn_raw[3] = 1'b1;
    repeat (30) @(negedge clk);
    bus.btn_raw[3] = 1'b0;
    repeat (70) @(negedge clk);
    bus.btn_raw[0] = 1'b0;
    repeat (40) @(negedge clk);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL missing_events: got %0d unmatched, required 0 (next rel_cyc=%0d ch=%0d kind=%0d)",
               sb.size(), sb[0].stamp - base, sb[0].ch, sb[0].kind);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
